// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32I memory-stage access engine.
// Provides XLEN, funct3 encodings for loads/stores, the access FSM state
// type and the legality check applied to an incoming load/store.
package riscv_mem_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // True when a load/store cannot be issued: conflicting direction,
  // unsupported size/sign encoding, or an address not aligned to its size.
  function automatic logic access_illegal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
    logic bad;
    bad = rd & wr;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) bad = 1'b1;
    if (wr && (f3 > F3_SW)) bad = 1'b1;
    if ((f3[1:0] == 2'b01) && lo[0]) bad = 1'b1;
    if ((f3[1:0] == 2'b10) && (lo != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: combinational load-data alignment and extension.
// Ports:
//   rdata   - raw 32-bit word returned by data memory
//   funct3  - load size/sign (LB/LH/LW/LBU/LHU)
//   addr_lo - byte offset within the word
//   data    - aligned, sign/zero-extended load result
module load_formatter
  import riscv_mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access engine of the 5-stage RV32I pipeline.
// Accepts the load/store in EX/MEM, latches the request (with forwarded store
// data if selected), runs one req/ack transaction on the data-memory port and
// stalls the pipeline until it completes.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   ex_mem_*                   - instruction held in EX/MEM
//   fwd_a, mem_wb_wdata        - store-data forwarding select and value
//   dmem_req/we/addr/be/wdata  - data-memory request (held stable in BUSY)
//   dmem_ack, dmem_rdata       - completion and read word (same cycle)
//   mem_stall                  - freezes IF..MEM while the access is open
//   load_data, load_valid      - formatted load result and its 1-cycle strobe
//   misaligned_exc             - 1-cycle pulse on a misaligned/illegal access
module mem_access_unit
  import riscv_mem_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_mem_valid,
  input  logic            ex_mem_mem_read,
  input  logic            ex_mem_mem_write,
  input  logic [2:0]      ex_mem_funct3,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] ex_mem_rs2_data,
  input  logic            fwd_a,
  input  logic [XLEN-1:0] mem_wb_wdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid,
  output logic            misaligned_exc
);

  mem_state_t state, state_next;

  logic            access;
  logic            illegal;
  logic            accept;
  logic [1:0]      addr_lo;
  logic [XLEN-1:0] store_src;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;
  logic [XLEN-1:0] fmt_data;

  logic            load_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic [XLEN-1:0] load_data_q;

  assign addr_lo = ex_mem_alu_result[1:0];
  assign access  = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
  assign illegal = access & access_illegal(ex_mem_mem_read, ex_mem_mem_write,
                                           ex_mem_funct3, addr_lo);
  assign accept  = (state == IDLE) & access & ~illegal;

  // MEM/WB is bubbled once we stall, so the forwarded value exists only in
  // the accept cycle and must be captured then.
  assign store_src = fwd_a ? mem_wb_wdata : ex_mem_rs2_data;

  always_comb begin
    be_next    = '1;
    wdata_next = '0;
    if (ex_mem_mem_write) begin
      case (ex_mem_funct3)
        F3_SB: begin
          be_next    = 4'b0001 << addr_lo;
          wdata_next = {4{store_src[7:0]}};
        end
        F3_SH: begin
          be_next    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{store_src[15:0]}};
        end
        default: begin
          be_next    = '1;
          wdata_next = store_src;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = BUSY;
      BUSY:    if (dmem_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      load_q      <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      load_data_q <= '0;
    end else begin
      if (accept) begin
        dmem_we    <= ex_mem_mem_write;
        dmem_addr  <= {ex_mem_alu_result[XLEN-1:2], 2'b00};
        dmem_be    <= be_next;
        dmem_wdata <= wdata_next;
        load_q     <= ex_mem_mem_read;
        funct3_q   <= ex_mem_funct3;
        addr_lo_q  <= addr_lo;
      end
      if ((state == BUSY) && dmem_ack && load_q) load_data_q <= fmt_data;
    end
  end

  load_formatter u_fmt (
    .rdata   (dmem_rdata),
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .data    (fmt_data)
  );

  // Decoded from state so an async reset drops the request immediately.
  assign dmem_req       = (state == BUSY);
  assign mem_stall      = accept | (state == BUSY);
  assign load_valid     = (state == DONE) & load_q;
  assign misaligned_exc = (state == IDLE) & illegal;
  assign load_data      = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_result, ex_mem_rs2_data, mem_wb_wdata;
  logic        fwd_a;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, load_valid, misaligned_exc;
  logic [31:0] load_data;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_funct3     (ex_mem_funct3),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_rs2_data   (ex_mem_rs2_data),
    .fwd_a             (fwd_a),
    .mem_wb_wdata      (mem_wb_wdata),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_be           (dmem_be),
    .dmem_wdata        (dmem_wdata),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .mem_stall         (mem_stall),
    .load_data         (load_data),
    .load_valid        (load_valid),
    .misaligned_exc    (misaligned_exc)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wdata;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_load_q[$];
  int unsigned exp_stall_q[$];
  int unsigned exc_tokens = 0;
  int unsigned reqs_expected = 0;
  int unsigned reqs_seen = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  int unsigned cur_waits = 0;
  logic [2:0]  cur_f3 = 3'd0;
  logic [1:0]  cur_off = 2'd0;
  bit          cur_load = 1'b0;
  bit          force_rd_en = 1'b0;
  logic [31:0] force_rd = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: access size in bytes from funct3.
  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic bit ref_illegal(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] addr);
    if (rd && wr) return 1'b1;
    if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (wr && f3 > 2) return 1'b1;
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    int unsigned sh, b, h;
    sh = w >> (8 * int'(off));
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Memory responder: acks after cur_waits BUSY cycles, random junk otherwise.
  initial begin : responder
    int unsigned wcnt;
    wcnt = 0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        wcnt = 0;
        dmem_ack = 1'b0;
      end else if (dmem_req) begin
        if (wcnt >= cur_waits) begin
          dmem_ack = 1'b1;
          dmem_rdata = force_rd_en ? force_rd : $urandom;
          if (cur_load) exp_load_q.push_back(ref_load(dmem_rdata, cur_f3, cur_off));
          wcnt = 0;
        end else begin
          dmem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        wcnt = 0;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  initial begin : monitor
    bit          in_req;
    req_t        cur;
    int unsigned run;
    in_req = 1'b0;
    run = 0;
    cur = '{addr: 32'd0, we: 1'b0, be: 4'd0, wdata: 32'd0, chk_wdata: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_req = 1'b0;
        run = 0;
        continue;
      end
      if (dmem_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          reqs_seen++;
          if (exp_req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
          else cur = exp_req_q.pop_front();
        end
        chk("req_addr", dmem_addr, cur.addr);
        chk("req_we", {31'd0, dmem_we}, {31'd0, cur.we});
        chk("req_be", {28'd0, dmem_be}, {28'd0, cur.be});
        if (cur.chk_wdata) chk("req_wdata", dmem_wdata, cur.wdata);
      end else begin
        in_req = 1'b0;
      end
      if (mem_stall) begin
        run++;
      end else if (run != 0) begin
        if (exp_stall_q.size() == 0) chk("unexpected_stall", run, 32'd0);
        else chk("stall_cycles", run, exp_stall_q.pop_front());
        run = 0;
      end
      if (load_valid) begin
        if (exp_load_q.size() == 0) chk("unexpected_load_valid", 32'd1, 32'd0);
        else chk("load_data", load_data, exp_load_q.pop_front());
      end
      if (misaligned_exc) begin
        chk("exc_expected", {31'd0, exc_tokens > 0}, 32'd1);
        if (exc_tokens > 0) exc_tokens--;
        chk("exc_no_req", {31'd0, dmem_req}, 32'd0);
        chk("exc_no_stall", {31'd0, mem_stall}, 32'd0);
      end
    end
  end

  task automatic set_inputs(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input bit fwd, input logic [31:0] wb, input int unsigned waits);
    cur_waits = waits;
    cur_f3 = f3;
    cur_off = addr[1:0];
    cur_load = rd;
    ex_mem_valid = 1'b1;
    ex_mem_mem_read = rd;
    ex_mem_mem_write = wr;
    ex_mem_funct3 = f3;
    ex_mem_alu_result = addr;
    ex_mem_rs2_data = rs2;
    fwd_a = fwd;
    mem_wb_wdata = wb;
  endtask

  function automatic req_t ref_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] rs2, input bit fwd, input logic [31:0] wb);
    req_t        r;
    int unsigned sz, d;
    sz = size_of(f3);
    d = fwd ? wb : rs2;
    r.addr = addr - (addr % 4);
    r.we = wr;
    r.chk_wdata = wr;
    if (wr) begin
      r.be = 4'(((1 << sz) - 1) << (addr % 4));
      r.wdata = (sz == 1) ? (d % 256) * 32'h01010101 :
                (sz == 2) ? (d % 65536) * 32'h00010001 : d;
    end else begin
      r.be = 4'hF;
      r.wdata = 32'd0;
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after the instruction leaves MEM.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input bit fwd, input logic [31:0] wb, input int unsigned waits);
    if (ref_illegal(rd, wr, f3, addr)) begin
      exc_tokens++;
    end else begin
      exp_req_q.push_back(ref_req(wr, f3, addr, rs2, fwd, wb));
      exp_stall_q.push_back(2 + waits);
      reqs_expected++;
    end
    set_inputs(rd, wr, f3, addr, rs2, fwd, wb, waits);
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (!mem_stall) break;
      if (c > 60) begin
        n_checks++;
        n_fail++;
        $display("FAIL stall_timeout: mem_stall still 1 after %0d cycles, expected release", c);
        break;
      end
      @(posedge clk);
      #1;
      mem_wb_wdata = $urandom;
      ex_mem_rs2_data = $urandom;
    end
    @(posedge clk);
    #1;
    ex_mem_valid = 1'b0;
    ex_mem_mem_read = 1'b0;
    ex_mem_mem_write = 1'b0;
  endtask

  initial begin : stimulus
    ex_mem_valid = 1'b0;
    ex_mem_mem_read = 1'b0;
    ex_mem_mem_write = 1'b0;
    ex_mem_funct3 = 3'd0;
    ex_mem_alu_result = 32'd0;
    ex_mem_rs2_data = 32'd0;
    fwd_a = 1'b0;
    mem_wb_wdata = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_valid", {31'd0, load_valid}, 32'd0);
    chk("rst_exc", {31'd0, misaligned_exc}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    access(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 0);
    access(1'b0, 1'b1, 3'd0, 32'h103, 32'h11223344, 1'b1, 32'h000000A5, 3);

    force_rd_en = 1'b1;
    force_rd = 32'h12805634;
    access(1'b1, 1'b0, 3'd0, 32'h202, 32'h0, 1'b0, 32'h0, 0);
    chk("lb_0x202", load_data, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'd4, 32'h202, 32'h0, 1'b0, 32'h0, 1);
    chk("lbu_0x202", load_data, 32'h00000080);
    force_rd_en = 1'b0;

    access(1'b1, 1'b0, 3'd1, 32'h301, 32'h0, 1'b0, 32'h0, 0);

    // LW with 5 wait cycles, reset pulled in the third BUSY cycle.
    exp_req_q.push_back(ref_req(1'b0, 3'd2, 32'h500, 32'h0, 1'b0, 32'h0));
    reqs_expected++;
    set_inputs(1'b1, 1'b0, 3'd2, 32'h500, 32'h0, 1'b0, 32'h0, 5);
    @(negedge clk);
    chk("lw_accept_stall", {31'd0, mem_stall}, 32'd1);
    repeat (3) @(negedge clk);
    chk("lw_busy3_req", {31'd0, dmem_req}, 32'd1);
    #1;
    rst_n = 1'b0;
    ex_mem_valid = 1'b0;
    ex_mem_mem_read = 1'b0;
    #1;
    chk("rst_mid_busy_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid_busy_stall", {31'd0, mem_stall}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(0, 1, 3'd2, 32'h504, 32'hCAFEF00D, 1'b0, 32'h0, 0);

    // Back-to-back SH then LHU to the same address.
    access(1'b0, 1'b1, 3'd1, 32'h402, 32'h0000BEEF, 1'b0, 32'h0, 1);
    access(1'b1, 1'b0, 3'd5, 32'h402, 32'h0, 1'b0, 32'h0, 2);

    for (int i = 0; i < 60; i++) begin
      int unsigned k;
      bit rd, wr;
      k = $urandom_range(0, 9);
      rd = (k <= 5);
      wr = (k == 0) || (k >= 6);
      access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4));
    end

    repeat (3) @(negedge clk);
    chk("req_count", reqs_seen, reqs_expected);
    chk("exc_outstanding", exc_tokens, 32'd0);
    chk("req_queue_left", exp_req_q.size(), 32'd0);
    chk("load_queue_left", exp_load_q.size(), 32'd0);
    chk("stall_queue_left", exp_stall_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
